// File: rtl/tx_fifo.sv
// rtl/tx_fifo.sv - transmit byte FIFO that feeds txshift one byte at a time
//
// Buffers bytes written on a single-cycle strobe and presents them to txshift
// one at a time, holding each byte until txshift reports completion.
//
// Ports:
//   i_Pclk       clock; all logic on the rising edge
//   i_Reset      asynchronous active-high reset
//   i_Wr_En      write strobe, one byte per cycle while high
//   i_Wr_Data    byte to enqueue
//   o_Full       FIFO holds DEPTH entries
//   o_Empty      FIFO holds no entries
//   o_Count      occupancy, 0..DEPTH
//   o_Overflow   sticky: a write was dropped because the FIFO was full
//   o_Tx_Enable  to txshift i_Enable
//   o_Tx_Data    to txshift i_Data
//   i_Tx_Pready  from txshift o_Pready; rising edge marks byte completion
//   o_Busy       feeder FSM is not idle
module tx_fifo #(
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3,
  parameter int GAP_CYCLES = 1
) (
  input  logic              i_Pclk,
  input  logic              i_Reset,
  input  logic              i_Wr_En,
  input  logic [7:0]        i_Wr_Data,
  output logic              o_Full,
  output logic              o_Empty,
  output logic [ADDR_W:0]   o_Count,
  output logic              o_Overflow,
  output logic              o_Tx_Enable,
  output logic [7:0]        o_Tx_Data,
  input  logic              i_Tx_Pready,
  output logic              o_Busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      GAP_LD  = 4'(GAP_CYCLES - 1);

  state_t            state, state_nxt;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count, count_nxt;
  logic              full, empty, overflow;
  logic              p_prev;
  logic [3:0]        gap_cnt, gap_cnt_nxt;
  logic [7:0]        tx_data;
  logic              done, pop, push;

  // Completion is a rising edge of Pready; a level that is already high when
  // a byte is launched must go low and high again before it counts.
  assign done = i_Tx_Pready & ~p_prev;

  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (done) begin
          state_nxt   = GAP;
          gap_cnt_nxt = GAP_LD;
        end
      end
      GAP: begin
        if (gap_cnt == 4'd0) state_nxt = IDLE;
        else                 gap_cnt_nxt = gap_cnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A full FIFO still accepts a write when the head leaves on the same edge.
  // An empty FIFO never pops, so a write into it is stored, not bypassed.
  assign push = i_Wr_En & (~full | pop);

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge i_Pclk or posedge i_Reset) begin
    if (i_Reset) begin
      state   <= IDLE;
      gap_cnt <= 4'd0;
      p_prev  <= 1'b0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_cnt_nxt;
      p_prev  <= i_Tx_Pready;
    end
  end

  always_ff @(posedge i_Pclk or posedge i_Reset) begin
    if (i_Reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        tx_data <= mem[rd_ptr];
      end
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_C);
      empty <= (count_nxt == '0);
      if (i_Wr_En && full && !pop) overflow <= 1'b1;
    end
  end

  // Storage has no reset; occupancy tracking alone decides what is valid.
  always_ff @(posedge i_Pclk) begin
    if (push) mem[wr_ptr] <= i_Wr_Data;
  end

  assign o_Full      = full;
  assign o_Empty     = empty;
  assign o_Count     = count;
  assign o_Overflow  = overflow;
  assign o_Tx_Enable = (state == SEND);
  assign o_Tx_Data   = tx_data;
  assign o_Busy      = (state != IDLE);

endmodule

// File: tb/tb_tx_fifo.sv
// tb/tb_tx_fifo.sv - randomized self-checking bench for tx_fifo
module tb_tx_fifo;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int GAP    = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            wr_en;
  logic [7:0]      wr_data;
  logic            full, empty, ovf, tx_en, busy;
  logic [ADDR_W:0] count;
  logic [7:0]      tx_data;
  logic            pready;

  always #5 clk = ~clk;

  tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .GAP_CYCLES(GAP)) dut (
    .i_Pclk(clk), .i_Reset(rst), .i_Wr_En(wr_en), .i_Wr_Data(wr_data),
    .o_Full(full), .o_Empty(empty), .o_Count(count), .o_Overflow(ovf),
    .o_Tx_Enable(tx_en), .o_Tx_Data(tx_data), .i_Tx_Pready(pready),
    .o_Busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: a byte queue plus "transmitter in use" flag and the
  // earliest edge at which the next byte may be launched.
  logic [7:0] mq[$];
  logic [7:0] sent[$];
  logic [7:0] m_cur;
  bit         m_send, m_prev, m_ovf, en_prev;
  int         cyc = 0;
  int         free_at = 0;

  function automatic bit pop_next();
    return !m_send && (cyc + 1) >= free_at && mq.size() > 0;
  endfunction

  task automatic model_reset();
    mq.delete();
    sent.delete();
    m_send  = 0;
    m_prev  = 0;
    m_ovf   = 0;
    en_prev = 0;
    free_at = 0;
  endtask

  // Called positioned just after a rising edge: drive, take one edge, model, check.
  task automatic step(input bit w, input logic [7:0] d, input bit p);
    bit is_done, is_pop, was_full;
    wr_en = w; wr_data = d; pready = p;
    @(posedge clk);
    cyc++;
    is_done  = m_send && p && !m_prev;
    is_pop   = !m_send && cyc >= free_at && mq.size() > 0;
    was_full = (mq.size() == DEPTH);
    if (is_pop) begin
      m_cur  = mq.pop_front();
      m_send = 1;
    end
    if (is_done) begin
      m_send  = 0;
      free_at = cyc + GAP + 1;
    end
    if (w) begin
      if (!was_full || is_pop) mq.push_back(d);
      else m_ovf = 1;
    end
    m_prev = p;
    #1;
    chk("count", 32'(count), mq.size());
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("overflow", 32'(ovf), 32'(m_ovf));
    chk("enable", 32'(tx_en), 32'(m_send));
    chk("busy", 32'(busy), 32'(m_send || cyc < free_at - 1));
    if (m_send) chk("data", 32'(tx_data), 32'(m_cur));
    if (tx_en && !en_prev) sent.push_back(tx_data);
    en_prev = tx_en;
  endtask

  task automatic drain();
    int n = 0;
    while ((mq.size() > 0 || m_send || cyc < free_at - 1) && n < 300) begin
      step(1'b0, 8'h00, (n % 3) == 2);
      n++;
    end
    chk("drain_bound", 32'(n < 300), 32'd1);
  endtask

  // Asserts reset between edges and checks that outputs clear without a clock.
  task automatic do_reset();
    #3;
    rst = 1'b1; wr_en = 1'b0; pready = 1'b0;
    #1;
    chk("rst_enable", 32'(tx_en), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_data", 32'(tx_data), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    bit found;
    int n;
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; pready = 1'b0;
    #1;
    chk("init_empty", 32'(empty), 32'd1);
    chk("init_full", 32'(full), 32'd0);
    chk("init_enable", 32'(tx_en), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();

    // Single byte, txshift completes 20 cycles later.
    step(1'b1, 8'h53, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("t1_enable", 32'(tx_en), 32'd1);
    chk("t1_data", 32'(tx_data), 32'h53);
    chk("t1_count", 32'(count), 32'd0);
    repeat (19) step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    chk("t1_drop", 32'(tx_en), 32'd0);
    drain();

    // Three back-to-back writes.
    sent.delete();
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    chk("t2_peak", 32'(count), 32'd2);
    drain();
    chk("t2_n", sent.size(), 32'd3);
    if (sent.size() == 3) begin
      chk("t2_b0", 32'(sent[0]), 32'h11);
      chk("t2_b1", 32'(sent[1]), 32'h22);
      chk("t2_b2", 32'(sent[2]), 32'h33);
    end

    // Fill while SEND is held, then overflow with 0xAA.
    sent.delete();
    step(1'b1, 8'h01, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'h80 + 8'(i), 1'b0);
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_count", 32'(count), 32'(DEPTH));
    step(1'b1, 8'hAA, 1'b0);
    chk("t3_ovf", 32'(ovf), 32'd1);
    drain();
    found = 0;
    foreach (sent[i]) if (sent[i] == 8'hAA) found = 1;
    chk("t3_no_aa", 32'(found), 32'd0);
    chk("t3_n", sent.size(), 32'(DEPTH + 1));

    // Reset mid-SEND with 4 queued and overflow still set.
    step(1'b1, 8'h02, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'h40 + 8'(i), 1'b0);
    chk("t6_pre_enable", 32'(tx_en), 32'd1);
    chk("t6_pre_ovf", 32'(ovf), 32'd1);
    do_reset();
    step(1'b1, 8'h5A, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("t6_enable", 32'(tx_en), 32'd1);
    chk("t6_data", 32'(tx_data), 32'h5A);
    drain();
    chk("t6_n", sent.size(), 32'd1);

    // Full FIFO, write 0x77 exactly on the IDLE pop edge.
    do_reset();
    step(1'b1, 8'hB0, 1'b0);
    n = 0;
    while (!(mq.size() == DEPTH && m_send) && n < 20) begin
      step(1'b1, 8'hC0 + 8'(n), 1'b0);
      n++;
    end
    chk("t4_full", 32'(full), 32'd1);
    step(1'b0, 8'h00, 1'b1);
    n = 0;
    while (!pop_next() && n < 20) begin
      step(1'b0, 8'h00, 1'b0);
      n++;
    end
    chk("t4_reach_pop", 32'(n < 20), 32'd1);
    step(1'b1, 8'h77, 1'b0);
    chk("t4_count", 32'(count), 32'(DEPTH));
    chk("t4_ovf", 32'(ovf), 32'd0);
    sent.delete();
    drain();
    chk("t4_n", sent.size(), 32'(DEPTH));
    if (sent.size() > 0) chk("t4_last", 32'(sent[sent.size()-1]), 32'h77);

    // Pready already high when SEND begins.
    do_reset();
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h3C, 1'b1);
    repeat (30) step(1'b0, 8'h00, 1'b1);
    chk("t5_hold", 32'(tx_en), 32'd1);
    step(1'b0, 8'h00, 1'b0);
    chk("t5_still", 32'(tx_en), 32'd1);
    step(1'b0, 8'h00, 1'b1);
    chk("t5_done", 32'(tx_en), 32'd0);
    drain();

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++)
      step(1'($urandom % 2), 8'($urandom), ($urandom % 4) == 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
